// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small circular FIFO.
// Ports:
//   clk, rst_n    - system clock, synchronous active-low reset
//   tx_data       - byte to queue
//   tx_valid      - tx_data is valid; written when tx_valid && tx_ready
//   tx_ready      - FIFO has a free slot (combinational from the count)
//   uart_tx_pin   - registered serial line, idles high
//   busy          - a frame is on the line or the FIFO holds bytes
//   fifo_count    - queued bytes, excluding the one being shifted
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx_pin,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               pin_q, pin_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic push, pop, baud_tick;

  assign tx_ready    = (count_q != CW'(FIFO_DEPTH));
  assign push        = tx_valid && tx_ready;
  assign baud_tick   = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign uart_tx_pin = pin_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign fifo_count  = count_q;

  // Frame sequencing; a pop loads the head byte and starts a new frame.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          // Back-to-back frames: next start bit follows the last stop cycle.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin is derived from the next state so it lines up with the state register.
  always_comb begin
    pin_d = 1'b1;
    unique case (state_d)
      START:   pin_d = 1'b0;
      DATA:    pin_d = shift_d[0];
      default: pin_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    rd_d    = pop  ? rd_q + PTR_W'(1) : rd_q;
    wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      pin_q   <= 1'b1;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only slots behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a
// frame-level reference model plus an independent serial-line decoder.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx_pin;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx_pin(uart_tx_pin),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Reference model: queued bytes, current frame byte, cycles left in frame.
  logic [7:0] mq[$];
  logic [7:0] cur_byte;
  int         left = 0;
  logic [7:0] exp_rx[$];

  // Line decoder state.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit         do_push;
    logic [7:0] d;
    if (!rst_n) begin
      mq.delete();
      left    = 0;
      rx_busy = 1'b0;
    end else begin
      do_push = tx_valid && (mq.size() != DEPTH);
      d       = tx_data;
      if (left > 0) begin
        left--;
        if (left == 0) exp_rx.push_back(cur_byte);
      end
      if (left == 0 && mq.size() > 0) begin
        cur_byte = mq.pop_front();
        left     = FRAME;
      end
      if (do_push) mq.push_back(d);
    end
  endtask

  function automatic logic exp_pin();
    int idx;
    if (left == 0) return 1'b1;
    idx = (FRAME - left) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return cur_byte[idx-1];
  endfunction

  task automatic decode_step();
    int idx;
    if (!rst_n) return;
    if (!rx_busy) begin
      if (uart_tx_pin == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        idx = rx_cnt / CPB;
        if (idx >= 1 && idx <= 8) begin
          rx_byte[idx-1] = uart_tx_pin;
        end else if (idx == 9) begin
          check_eq("stop_bit", 32'(uart_tx_pin), 32'd1);
          rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  endtask

  // One clock: advance the model at the edge, compare #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_eq("pin",   32'(uart_tx_pin), 32'(exp_pin()));
    check_eq("count", 32'(fifo_count),  32'(mq.size()));
    check_eq("ready", 32'(tx_ready),    32'(mq.size() != DEPTH));
    check_eq("busy",  32'(busy),        32'((left > 0) || (mq.size() > 0)));
    decode_step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy && k < 5000) begin
      cycle();
      k++;
    end
    check_eq("drain_timeout", 32'(k < 5000), 32'd1);
  endtask

  initial begin
    int k, acc, drop_at, e0;
    bit r;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    cycle(); cycle();
    check_eq("rst_pin",   32'(uart_tx_pin), 32'd1);
    check_eq("rst_count", 32'(fifo_count),  32'd0);
    check_eq("rst_ready", 32'(tx_ready),    32'd1);
    check_eq("rst_busy",  32'(busy),        32'd0);
    rst_n = 1'b1;
    cycle();

    // Single byte 0xA5 from idle.
    tx_data = 8'hA5; tx_valid = 1'b1;
    cycle();
    tx_valid = 1'b0;
    check_eq("a5_count_e0", 32'(fifo_count), 32'd1);
    cycle();
    check_eq("a5_pin_e1", 32'(uart_tx_pin), 32'd0);
    check_eq("a5_count_e1", 32'(fifo_count), 32'd0);
    k = 1;
    while (busy && k < 200) begin
      cycle();
      k++;
    end
    check_eq("a5_busy_drop", 32'(k), 32'd41);

    // Burst 0x01..0x06 with tx_valid held high.
    acc = 0; drop_at = -1; e0 = 0; k = 0;
    while (acc < 6 && k < 400) begin
      tx_data  = 8'(acc + 1);
      tx_valid = 1'b1;
      r = tx_ready;
      if (r && acc == 0) e0 = cyc + 1;
      cycle();
      k++;
      if (r) acc++;
      else if (drop_at < 0) drop_at = acc;
    end
    tx_valid = 1'b0;
    check_eq("burst_accept_before_full", 32'(drop_at), 32'd5);
    check_eq("burst_all_accepted", 32'(acc), 32'd6);
    drain();
    check_eq("burst_span", 32'(cyc - e0 - 1), 32'd240);

    // Push on the exact STOP->START pop edge with two bytes queued.
    tx_data = 8'h11; tx_valid = 1'b1; cycle();
    tx_data = 8'h22; cycle();
    tx_data = 8'h33; cycle();
    tx_valid = 1'b0;
    repeat (38) cycle();
    check_eq("pre_pop_count", 32'(fifo_count), 32'd2);
    tx_data = 8'h44; tx_valid = 1'b1;
    cycle();
    tx_valid = 1'b0;
    check_eq("pushpop_count", 32'(fifo_count), 32'd2);
    check_eq("pushpop_start", 32'(uart_tx_pin), 32'd0);
    drain();

    // Reset during data bit 3 of 0x0F with two bytes queued.
    tx_data = 8'h0F; tx_valid = 1'b1; cycle();
    tx_data = 8'h33; cycle();
    tx_data = 8'h44; cycle();
    tx_valid = 1'b0;
    repeat (15) cycle();
    check_eq("mid_bit3", 32'(uart_tx_pin), 32'd1);
    check_eq("mid_count", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_eq("midrst_pin",   32'(uart_tx_pin), 32'd1);
    check_eq("midrst_count", 32'(fifo_count),  32'd0);
    check_eq("midrst_busy",  32'(busy),        32'd0);
    cycle();
    check_eq("midrst_idle_pin", 32'(uart_tx_pin), 32'd1);
    tx_data = 8'h55; tx_valid = 1'b1; cycle();
    tx_valid = 1'b0;
    drain();
    check_eq("post_rst_byte", 32'(rx_q[rx_q.size()-1]), 32'h55);

    // Random traffic.
    repeat (600) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      cycle();
    end
    tx_valid = 1'b0;
    drain();

    check_eq("rx_total", 32'(rx_q.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++) begin
      check_eq("rx_byte", 32'(rx_q[i]), 32'(exp_rx[i]));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
